isp_cfg_sequencer: RTL and testbench
====================================

# isp_cfg_sequencer

Frame-synchronous configuration sequencer between the AHB-Lite ISP register slave and the ISP pixel datapath. Software writes the coefficients, enable and split-point fields, then issues a commit. This block holds the values in a pending shadow set and applies them atomically at the next frame start, so the datapath never sees a half-updated configuration mid-frame. It also tracks frame state, counts processed frames and flags protocol errors.

## Interface
- `H_ACTIVE`, default 1280: active pixels per line; upper bound for the split-x clamp.
- `V_ACTIVE`, default 720: active lines per frame; upper bound for the split-y clamp.
- `HCLK` in 1: single clock domain.
- `HRESET` in 1: reset, asynchronous and active-high.
- `cfg_num0to7` in 32: coefficient word 0 from the register slave.
- `cfg_num8to15` in 32: coefficient word 1.
- `cfg_en` in 1: requested ISP enable.
- `cfg_split_x` in 11: requested split column.
- `cfg_split_y` in 11: requested split row.
- `cfg_commit` in 1: one-cycle pulse; captures all `cfg_*` inputs into the pending set.
- `frame_start` in 1: one-cycle pulse at the frame boundary, already synchronous to `HCLK`.
- `frame_end` in 1: one-cycle pulse after the last active pixel.
- `err_clr` in 1: clears the sticky error flags.
- `isp_num0to7` out 32: applied coefficient word 0.
- `isp_num8to15` out 32: applied coefficient word 1.
- `isp_en` out 1: applied ISP enable.
- `isp_split_x` out 11: applied split column.
- `isp_split_y` out 11: applied split row.
- `cfg_pending` out 1: high while a committed set is waiting to be applied.
- `cfg_applied` out 1: one-cycle pulse when the pending set is transferred to the outputs.
- `in_frame` out 1: high between an accepted `frame_start` and `frame_end` while `isp_en`=1.
- `frame_cnt` out 16: frames started while enabled.
- `err_overrun` out 1: sticky; a commit overwrote a set that was still pending.
- `err_sync` out 1: sticky; `frame_start` arrived while `in_frame`=1.

## Operation
- **Reset.** All outputs are 0. The pending set is cleared. The state machine goes to IDLE.
- **Commit.** On `cfg_commit`, the pending set captures `cfg_*` and `cfg_pending` goes to 1.
  - Split clamp at capture: x is stored as min(`cfg_split_x`, H_ACTIVE-1); y is stored as min(`cfg_split_y`, V_ACTIVE-1).
- **Apply.** On `frame_start` with `cfg_pending`=1:
  - The pending set is copied to the `isp_*` outputs.
  - `cfg_pending` is cleared and `cfg_applied` pulses.
  - The applied enable value selects the state transition.
- **States:**
  - IDLE (`isp_en`=0): `frame_start` with a pending set whose enable=1 → ACTIVE. Otherwise remain in IDLE; the frame is ignored.
  - ACTIVE (`in_frame`=1): `frame_end` → GAP. `frame_start` → set `err_sync`, apply the pending set if present, treat as a new frame and stay in ACTIVE.
  - GAP (enabled, between frames): `frame_start` → ACTIVE.
  - Any apply with enable=0 → IDLE immediately; `in_frame` drops.
- **Frame counter.** `frame_cnt` increments by 1 on each `frame_start` that enters or stays in ACTIVE. It wraps from 0xFFFF to 0. It is not cleared on disable.
- **Stray `frame_end`.** A `frame_end` in IDLE or GAP is ignored.
- **Overrun.** `cfg_commit` while `cfg_pending`=1 overwrites the pending set and sets `err_overrun`.
- **Error clear.** `err_clr` clears both sticky flags. If an error event occurs in the same cycle as `err_clr`, the flag is set (set wins).

## Timing
- `frame_start` at cycle N with a set pending: the `isp_*` outputs, `cfg_applied`, the state and `frame_cnt` all update at N+1. All are registered outputs.
- `cfg_commit` at cycle N: `cfg_pending`=1 at N+1.
- `cfg_commit` and `frame_start` in the same cycle:
  - The apply uses the previously pending set if one exists; otherwise nothing is applied.
  - The new commit becomes pending for the next frame.
  - `err_overrun` is not set.
- `frame_start` and `frame_end` in the same cycle: `frame_end` is processed first, then `frame_start`.
  - Net effect from ACTIVE: stays in ACTIVE, with no `err_sync`.
- Asserting `HRESET` mid-frame forces all outputs to 0 asynchronously. After release, the block waits in IDLE for a commit.

## Structure
- Shared package `isp_pkg`:
  - Enum `isp_seq_state_t` {IDLE, ACTIVE, GAP}.
  - Struct `isp_cfg_t` {num0to7, num8to15, en, split_x, split_y}.
  - Constant `ISP_SPLIT_W`=11.
- Sub-module `isp_cfg_shadow`: holds the pending register, the clamp logic, the pending flag and the overrun detection.
- The top level holds the FSM, the applied register, the frame counter and the error flags.

## Test plan
- **Basic apply.** Reset, then commit {0x00320000, 0x40, en=1, x=100, y=50}, then `frame_start` → outputs equal those values one cycle later, `cfg_applied` pulses once, `frame_cnt`=1, `in_frame`=1.
- **Clamp.** Commit x=2047, y=2047 with defaults → applied x=1279, y=719.
- **Overrun.** Commit A, then commit B before any `frame_start` → `err_overrun`=1 and B is applied. `err_clr` clears the flag. A same-cycle error event and `err_clr` → flag stays 1.
- **Same-cycle commit and frame_start.**
  - Commit A, then `frame_start` and commit B in the same cycle → A is applied, B stays pending.
  - The next `frame_start` applies B. No overrun is flagged.
- **Sync error and disable.** In ACTIVE, issue `frame_start` without `frame_end` → `err_sync`=1 and `frame_cnt` increments. Then commit en=0 and `frame_start` → IDLE, `isp_en`=0, `in_frame`=0.
- **Wrap and reset.** Preload `frame_cnt` to 0xFFFF via 65535 frames → the next frame gives 0. Assert `HRESET` mid-frame → all outputs are 0 in the same cycle.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared types for the ISP configuration sequencer: FSM states and the
// configuration set that moves from the register slave to the pixel datapath.
package isp_pkg;

  localparam int ISP_SPLIT_W = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } isp_seq_state_t;

  typedef struct packed {
    logic [31:0]            num0to7;
    logic [31:0]            num8to15;
    logic                   en;
    logic [ISP_SPLIT_W-1:0] split_x;
    logic [ISP_SPLIT_W-1:0] split_y;
  } isp_cfg_t;

endpackage

// File: rtl/isp_cfg_sequencer_if.sv
// Register-slave / frame-sync side of the sequencer and the applied outputs
// toward the datapath. master = stimulus/register side, slave = sequencer.
interface isp_cfg_sequencer_if;
  logic [31:0] cfg_num0to7;
  logic [31:0] cfg_num8to15;
  logic        cfg_en;
  logic [10:0] cfg_split_x;
  logic [10:0] cfg_split_y;
  logic        cfg_commit;
  logic        frame_start;
  logic        frame_end;
  logic        err_clr;
  logic [31:0] isp_num0to7;
  logic [31:0] isp_num8to15;
  logic        isp_en;
  logic [10:0] isp_split_x;
  logic [10:0] isp_split_y;
  logic        cfg_pending;
  logic        cfg_applied;
  logic        in_frame;
  logic [15:0] frame_cnt;
  logic        err_overrun;
  logic        err_sync;

  modport master (
    output cfg_num0to7, cfg_num8to15, cfg_en, cfg_split_x, cfg_split_y,
           cfg_commit, frame_start, frame_end, err_clr,
    input  isp_num0to7, isp_num8to15, isp_en, isp_split_x, isp_split_y,
           cfg_pending, cfg_applied, in_frame, frame_cnt, err_overrun, err_sync
  );

  modport slave (
    input  cfg_num0to7, cfg_num8to15, cfg_en, cfg_split_x, cfg_split_y,
           cfg_commit, frame_start, frame_end, err_clr,
    output isp_num0to7, isp_num8to15, isp_en, isp_split_x, isp_split_y,
           cfg_pending, cfg_applied, in_frame, frame_cnt, err_overrun, err_sync
  );
endinterface

// File: rtl/isp_cfg_shadow.sv
// Pending (shadow) configuration set: split clamping at capture, pending flag,
// and overrun detection when a commit replaces a set nobody consumed.
module isp_cfg_shadow
  import isp_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic     HCLK,
  input  logic     HRESET,
  input  logic     commit,
  input  logic     frame_start,
  input  isp_cfg_t cfg,
  output isp_cfg_t pend,
  output logic     pending,
  output logic     overrun_evt
);

  localparam logic [ISP_SPLIT_W-1:0] X_MAX = ISP_SPLIT_W'(H_ACTIVE - 1);
  localparam logic [ISP_SPLIT_W-1:0] Y_MAX = ISP_SPLIT_W'(V_ACTIVE - 1);

  isp_cfg_t clamped;

  always_comb begin
    clamped         = cfg;
    clamped.split_x = (cfg.split_x > X_MAX) ? X_MAX : cfg.split_x;
    clamped.split_y = (cfg.split_y > Y_MAX) ? Y_MAX : cfg.split_y;
  end

  // A frame_start in the same cycle consumes the old set, so the new commit
  // replaces nothing and is not an overrun.
  assign overrun_evt = commit & pending & ~frame_start;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend    <= '0;
      pending <= 1'b0;
    end else begin
      if (commit) pend <= clamped;
      if (commit)                     pending <= 1'b1;
      else if (frame_start & pending) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/isp_cfg_sequencer.sv
// Frame-synchronous config sequencer: applies the pending set atomically at
// frame start, tracks frame state, counts frames and keeps sticky errors.
module isp_cfg_sequencer
  import isp_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  isp_cfg_sequencer_if.slave   bus
);

  isp_cfg_t       cfg_in, pend, app;
  logic           pending, overrun_evt, take;
  logic           applied_q, err_ov_q, err_sy_q;
  logic [15:0]    cnt_q;
  isp_seq_state_t state, state_nx, eff;
  logic           cnt_inc, sync_evt;

  assign cfg_in = '{num0to7:  bus.cfg_num0to7,
                    num8to15: bus.cfg_num8to15,
                    en:       bus.cfg_en,
                    split_x:  bus.cfg_split_x,
                    split_y:  bus.cfg_split_y};

  isp_cfg_shadow #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_shadow (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .commit      (bus.cfg_commit),
    .frame_start (bus.frame_start),
    .cfg         (cfg_in),
    .pend        (pend),
    .pending     (pending),
    .overrun_evt (overrun_evt)
  );

  assign take = bus.frame_start & pending;

  // frame_end is folded in first so a coincident frame_start sees GAP.
  always_comb begin
    eff = state;
    if (state == ACTIVE && bus.frame_end) eff = GAP;
    state_nx = eff;
    cnt_inc  = 1'b0;
    sync_evt = 1'b0;
    if (bus.frame_start) begin
      sync_evt = (eff == ACTIVE);
      if (take && !pend.en) begin
        state_nx = IDLE;
      end else if (eff != IDLE || take) begin
        state_nx = ACTIVE;
        cnt_inc  = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      app       <= '0;
      applied_q <= 1'b0;
      cnt_q     <= '0;
      err_ov_q  <= 1'b0;
      err_sy_q  <= 1'b0;
    end else begin
      state     <= state_nx;
      applied_q <= take;
      if (take)    app   <= pend;
      if (cnt_inc) cnt_q <= cnt_q + 16'd1;
      // Error events take priority over a coincident clear.
      if (overrun_evt)      err_ov_q <= 1'b1;
      else if (bus.err_clr) err_ov_q <= 1'b0;
      if (sync_evt)         err_sy_q <= 1'b1;
      else if (bus.err_clr) err_sy_q <= 1'b0;
    end
  end

  assign bus.isp_num0to7  = app.num0to7;
  assign bus.isp_num8to15 = app.num8to15;
  assign bus.isp_en       = app.en;
  assign bus.isp_split_x  = app.split_x;
  assign bus.isp_split_y  = app.split_y;
  assign bus.cfg_pending  = pending;
  assign bus.cfg_applied  = applied_q;
  assign bus.in_frame     = (state == ACTIVE);
  assign bus.frame_cnt    = cnt_q;
  assign bus.err_overrun  = err_ov_q;
  assign bus.err_sync     = err_sy_q;

endmodule

// File: tb/tb_isp_cfg_sequencer.sv
// Directed bench: stimulus pushes expected applied sets into a queue, a
// negedge monitor pops and compares on every cfg_applied pulse.
module tb_isp_cfg_sequencer;
  import isp_pkg::*;

  typedef struct {
    logic [31:0] n0;
    logic [31:0] n1;
    logic        en;
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] cnt;
    logic        inf;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  isp_cfg_sequencer_if bus ();

  isp_cfg_sequencer #(.H_ACTIVE(1280), .V_ACTIVE(720)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every applied pulse must match the oldest expected set.
  always @(negedge HCLK) begin
    if (!HRESET && bus.cfg_applied === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_apply: got pulse expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("apply_n0",  bus.isp_num0to7,  e.n0);
        chk("apply_n1",  bus.isp_num8to15, e.n1);
        chk("apply_en",  32'(bus.isp_en),  32'(e.en));
        chk("apply_x",   32'(bus.isp_split_x), 32'(e.x));
        chk("apply_y",   32'(bus.isp_split_y), 32'(e.y));
        chk("apply_cnt", 32'(bus.frame_cnt),   32'(e.cnt));
        chk("apply_inf", 32'(bus.in_frame),    32'(e.inf));
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] n0, input logic [31:0] n1, input logic en,
                         input logic [10:0] x, input logic [10:0] y);
    bus.cfg_num0to7 = n0; bus.cfg_num8to15 = n1; bus.cfg_en = en;
    bus.cfg_split_x = x;  bus.cfg_split_y = y;
  endtask

  // One cycle with the given pulses asserted.
  task automatic step(input logic fs, input logic fe, input logic cm, input logic clr);
    bus.frame_start = fs; bus.frame_end = fe; bus.cfg_commit = cm; bus.err_clr = clr;
    tick();
    bus.frame_start = 0; bus.frame_end = 0; bus.cfg_commit = 0; bus.err_clr = 0;
  endtask

  task automatic push(input logic [31:0] n0, input logic [31:0] n1, input logic en,
                      input logic [10:0] x, input logic [10:0] y, input logic [15:0] c,
                      input logic inf);
    exp_t e;
    e.n0 = n0; e.n1 = n1; e.en = en; e.x = x; e.y = y; e.cnt = c; e.inf = inf;
    q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_n0"},  bus.isp_num0to7, 32'h0);
    chk({tag, "_n1"},  bus.isp_num8to15, 32'h0);
    chk({tag, "_sig"}, 32'({bus.isp_en, bus.cfg_pending, bus.cfg_applied, bus.in_frame,
                            bus.err_overrun, bus.err_sync}), 32'h0);
    chk({tag, "_xy"},  32'({bus.isp_split_x, bus.isp_split_y}), 32'h0);
    chk({tag, "_cnt"}, 32'(bus.frame_cnt), 32'h0);
  endtask

  initial begin
    set_cfg(0, 0, 0, 0, 0);
    bus.cfg_commit = 0; bus.frame_start = 0; bus.frame_end = 0; bus.err_clr = 0;
    repeat (3) tick();
    chk_all_zero("reset");
    HRESET = 0;
    tick();

    // Basic apply
    set_cfg(32'h0032_0000, 32'h40, 1, 100, 50);
    step(0, 0, 1, 0);
    chk("pending_set", 32'(bus.cfg_pending), 1);
    push(32'h0032_0000, 32'h40, 1, 100, 50, 16'd1, 1);
    step(1, 0, 0, 0);
    chk("pending_clr", 32'(bus.cfg_pending), 0);
    tick();
    chk("applied_one_cycle", 32'(bus.cfg_applied), 0);
    step(0, 1, 0, 0);
    chk("gap_in_frame", 32'(bus.in_frame), 0);

    // Clamp
    set_cfg(32'h1, 32'h2, 1, 11'd2047, 11'd2047);
    step(0, 0, 1, 0);
    push(32'h1, 32'h2, 1, 11'd1279, 11'd719, 16'd2, 1);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);

    // Overrun: B replaces A
    set_cfg(32'hA, 32'hA, 1, 1, 1);
    step(0, 0, 1, 0);
    chk("no_overrun_yet", 32'(bus.err_overrun), 0);
    set_cfg(32'hB, 32'hB0, 1, 10, 20);
    step(0, 0, 1, 0);
    chk("overrun_set", 32'(bus.err_overrun), 1);
    push(32'hB, 32'hB0, 1, 10, 20, 16'd3, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("overrun_clr", 32'(bus.err_overrun), 0);
    set_cfg(32'hC, 32'hC0, 1, 3, 4);
    step(0, 0, 1, 0);
    set_cfg(32'hD, 32'hD0, 1, 30, 40);
    step(0, 0, 1, 1);
    chk("overrun_set_wins", 32'(bus.err_overrun), 1);
    step(0, 1, 0, 0);
    push(32'hD, 32'hD0, 1, 30, 40, 16'd4, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("overrun_clr2", 32'(bus.err_overrun), 0);

    // Same-cycle commit and frame_start
    step(0, 1, 0, 0);
    set_cfg(32'h111, 32'h222, 1, 5, 6);
    step(0, 0, 1, 0);
    push(32'h111, 32'h222, 1, 5, 6, 16'd5, 1);
    set_cfg(32'h333, 32'h444, 1, 7, 8);
    step(1, 0, 1, 0);
    chk("same_cyc_pending", 32'(bus.cfg_pending), 1);
    chk("same_cyc_no_ovr", 32'(bus.err_overrun), 0);
    step(0, 1, 0, 0);
    push(32'h333, 32'h444, 1, 7, 8, 16'd6, 1);
    step(1, 0, 0, 0);
    chk("second_pending_clr", 32'(bus.cfg_pending), 0);
    chk("second_no_ovr", 32'(bus.err_overrun), 0);

    // Coincident frame_end + frame_start: no sync error
    step(1, 1, 0, 0);
    chk("fe_fs_no_sync", 32'(bus.err_sync), 0);
    chk("fe_fs_cnt", 32'(bus.frame_cnt), 7);

    // Sync error, then disable
    step(1, 0, 0, 0);
    chk("sync_err", 32'(bus.err_sync), 1);
    chk("sync_cnt", 32'(bus.frame_cnt), 8);
    set_cfg(32'h5, 32'h6, 0, 1, 2);
    step(0, 0, 1, 0);
    push(32'h5, 32'h6, 0, 1, 2, 16'd8, 0);
    step(1, 0, 0, 0);
    chk("disable_en", 32'(bus.isp_en), 0);
    chk("disable_inf", 32'(bus.in_frame), 0);
    step(0, 0, 0, 1);
    chk("sync_clr", 32'(bus.err_sync), 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("idle_ignore_inf", 32'(bus.in_frame), 0);
    chk("idle_ignore_cnt", 32'(bus.frame_cnt), 8);

    // Wrap
    set_cfg(32'h77, 32'h88, 1, 9, 9);
    step(0, 0, 1, 0);
    push(32'h77, 32'h88, 1, 9, 9, 16'd9, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 65535 - 9; i++) step(1, 1, 0, 0);
    chk("cnt_max", 32'(bus.frame_cnt), 32'hFFFF);
    chk("wrap_no_sync", 32'(bus.err_sync), 0);
    step(1, 1, 0, 0);
    chk("cnt_wrap", 32'(bus.frame_cnt), 0);
    chk("wrap_inf", 32'(bus.in_frame), 1);

    // Async reset mid-frame with a set pending
    set_cfg(32'h99, 32'h99, 1, 9, 9);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    #2 HRESET = 1;
    #1;
    chk_all_zero("async_rst");
    tick();
    HRESET = 0;
    tick();
    step(1, 0, 0, 0);
    chk("post_rst_idle", 32'(bus.in_frame), 0);
    chk("post_rst_cnt", 32'(bus.frame_cnt), 0);
    tick();

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
